// File: rtl/dcache_pkg.sv
// Shared types and address field layout for the direct-mapped data cache controller.
package dcache_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 3;
    localparam int IDX_W  = 5;
    localparam int OFF_W  = 2;

    localparam int OFF_LSB = 0;
    localparam int IDX_LSB = OFF_LSB + OFF_W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dcache_if.sv
// Processor-side and backing-memory-side signals of the data cache, grouped for port hookup.
interface dcache_if;
    import dcache_pkg::*;

    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] WordAddress;
    logic [DATA_W-1:0] DataIn;
    logic              Stall;
    logic [DATA_W-1:0] DataOut;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  MemRead, MemWrite, WordAddress, DataIn, mem_rdata, mem_ack,
        output Stall, DataOut, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output MemRead, MemWrite, WordAddress, DataIn, mem_rdata, mem_ack,
        input  Stall, DataOut, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dcache_array.sv
// Tag, valid and data storage for the direct-mapped cache: one async read port, one write port.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int LINES = 32,
    parameter int WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [OFF_W-1:0]  rd_off,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic              wr_tag_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [TAG_W-1:0]  wr_tag
);

    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES][WORDS];

    always_comb begin
        valid_d = valid_q;
        if (wr_tag_en) valid_d[wr_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) valid_q <= '0;
        else      valid_q <= valid_d;
    end

    // Payload storage needs no reset: nothing is trusted until its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en)     data_mem[wr_idx][wr_off] <= wr_data;
        if (wr_tag_en) tag_mem[wr_idx]          <= wr_tag;
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx][rd_off];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache controller with line refill.
// Defining DCACHE_STATS_EN adds saturating hit_cnt/miss_cnt read statistics outputs.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES = 32,
    parameter int WORDS = 4
) (
    input  logic clk,
    input  logic rst,
    dcache_if.slave bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
`endif
);

    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(WORDS - 1);

    state_e            state_q, state_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;

    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [OFF_W-1:0]  off;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              hit;

    logic              wr_en, wr_tag_en;
    logic [OFF_W-1:0]  wr_off;
    logic [DATA_W-1:0] wr_data;

    logic              stall;
    logic [DATA_W-1:0] dout;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    assign tag = bus.WordAddress[TAG_LSB +: TAG_W];
    assign idx = bus.WordAddress[IDX_LSB +: IDX_W];
    assign off = bus.WordAddress[OFF_LSB +: OFF_W];
    assign hit = rd_valid && (rd_tag == tag);

    dcache_array #(
        .LINES (LINES),
        .WORDS (WORDS)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (idx),
        .rd_off    (off),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_tag_en (wr_tag_en),
        .wr_idx    (idx),
        .wr_off    (wr_off),
        .wr_data   (wr_data),
        .wr_tag    (tag)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are gated by rst so the bus is quiet during reset even with a request held.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall     = 1'b0;
        dout      = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = bus.WordAddress;
        mem_wdata = '0;
        wr_en     = 1'b0;
        wr_tag_en = 1'b0;
        wr_off    = off;
        wr_data   = bus.DataIn;
        if (rst) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.MemWrite) begin
                        stall   = 1'b1;
                        state_d = WRITE;
                    end else if (bus.MemRead) begin
                        if (hit) begin
                            dout = rd_data;
                        end else begin
                            stall   = 1'b1;
                            cnt_d   = '0;
                            state_d = REFILL;
                        end
                    end
                end
                REFILL: begin
                    stall    = 1'b1;
                    mem_req  = 1'b1;
                    mem_addr = {tag, idx, cnt_q};
                    wr_off   = cnt_q;
                    wr_data  = bus.mem_rdata;
                    if (bus.mem_ack) begin
                        wr_en = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST_OFF) begin
                            wr_tag_en = 1'b1;
                            state_d   = IDLE;
                        end
                    end
                end
                WRITE: begin
                    stall     = 1'b1;
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_wdata = bus.DataIn;
                    if (bus.mem_ack) begin
                        wr_en   = hit;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.Stall     = stall;
    assign bus.DataOut   = dout;
    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;

`ifdef DCACHE_STATS_EN
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic             refilled_q, refilled_d;

    // The hit that completes a refilled read belongs to the same access as its miss.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        refilled_d = (state_q == REFILL) && (state_d == IDLE);
        if (state_q == IDLE && bus.MemRead && !bus.MemWrite) begin
            if (!hit)             miss_cnt_d = sat_inc(miss_cnt_q);
            else if (!refilled_q) hit_cnt_d  = sat_inc(hit_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            refilled_q <= 1'b0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            refilled_q <= refilled_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule
